cross_bar_nxm: RTL and testbench

Parametrised N-master × M-slave crossbar for the request/acknowledge bus (req, addr, cmd, wdata / ack, rdata). It is the multi-port generalisation of the single point-to-point bus. Each slave port has its own round-robin arbiter, so transactions to different slaves run concurrently. It sits between the core-side masters and the memory/peripheral slaves.

---
 rtl/cross_bar_pkg.sv | 23 ++
 rtl/cross_bar_rr_arbiter.sv | 80 ++++++++
 rtl/cross_bar_nxm.sv | 104 ++++++++++
 tb/tb_cross_bar_nxm.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cross_bar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar_pkg
// Description : Shared types and constants for the N-master x M-slave
//               request/acknowledge crossbar.
// Contents    : default bus widths, command encodings, per-slave FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
package cross_bar_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } slv_state_t;

endpackage
`default_nettype wire

// File: rtl/cross_bar_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar_rr_arbiter
// Description : Round-robin arbiter with IDLE/BUSY ownership FSM for one
//               slave port. A grant is taken in IDLE and held until the
//               slave completes; the pointer then moves past the winner.
// Ports       : clk, rst_n        - clock, async active-low reset
//               req_vec[N]        - requests decoded for this slave
//               release_grant     - slave completion (ignored while IDLE)
//               grant_idx         - index of the master owning the slave
//               busy              - slave currently owned
// Revision    : 1.0 - initial release
// ============================================================================
module cross_bar_rr_arbiter
   import cross_bar_pkg::*;
#(
   parameter  int N     = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_vec,
   // named release_grant because "release" is a reserved word
   input  logic             release_grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             busy
);

   slv_state_t       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] winner;
   int               idx;

   // Scan from the farthest offset down to offset 0 so the candidate
   // closest to (at or after) rr_ptr is the last one written.
   always_comb begin
      winner = rr_ptr_q;
      idx    = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (req_vec[idx]) winner = IDX_W'(idx);
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      if (state_q == IDLE) begin
         if (|req_vec) begin
            grant_d = winner;
            state_d = BUSY;
         end
      end else begin
         if (release_grant) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == IDX_W'(N - 1)) ? '0 : grant_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign grant_idx = grant_q;
   assign busy      = (state_q == BUSY);

endmodule
`default_nettype wire

// File: rtl/cross_bar_nxm.sv
`default_nettype none
// ============================================================================
// Module      : cross_bar_nxm
// Description : N-master x M-slave request/acknowledge crossbar. The top
//               address bits select the slave; every slave has its own
//               round-robin arbiter so different slaves run concurrently.
// Ports       : clk, rst_n                         - clock, async active-low reset
//               m_req/m_addr/m_cmd/m_wdata         - master requests
//               m_ack/m_rdata                      - completion back to masters
//               s_req/s_addr/s_cmd/s_wdata         - forwarded requests
//               s_ack/s_rdata                      - slave completions
// Revision    : 1.0 - initial release
// ============================================================================
module cross_bar_nxm
   import cross_bar_pkg::*;
#(
   parameter  int N_MASTERS  = 2,
   parameter  int N_SLAVES   = 2,
   parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   localparam int SEL_W      = $clog2(N_SLAVES),
   localparam int MIDX_W     = $clog2(N_MASTERS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_MASTERS-1:0]  m_req,
   input  logic [ADDR_WIDTH-1:0] m_addr  [N_MASTERS],
   input  logic [N_MASTERS-1:0]  m_cmd,
   input  logic [DATA_WIDTH-1:0] m_wdata [N_MASTERS],
   output logic [N_MASTERS-1:0]  m_ack,
   output logic [DATA_WIDTH-1:0] m_rdata [N_MASTERS],
   output logic [N_SLAVES-1:0]   s_req,
   output logic [ADDR_WIDTH-1:0] s_addr  [N_SLAVES],
   output logic [N_SLAVES-1:0]   s_cmd,
   output logic [DATA_WIDTH-1:0] s_wdata [N_SLAVES],
   input  logic [N_SLAVES-1:0]   s_ack,
   input  logic [DATA_WIDTH-1:0] s_rdata [N_SLAVES]
);

   logic [N_MASTERS-1:0] req_vec [N_SLAVES];
   logic [MIDX_W-1:0]    grant   [N_SLAVES];
   logic [N_SLAVES-1:0]  busy;

   // Full decode: every address maps onto exactly one slave.
   always_comb begin
      for (int s = 0; s < N_SLAVES; s++) begin
         for (int m = 0; m < N_MASTERS; m++) begin
            req_vec[s][m] = m_req[m] &&
                            (m_addr[m][ADDR_WIDTH-1 -: SEL_W] == SEL_W'(s));
         end
      end
   end

   generate
      for (genvar s = 0; s < N_SLAVES; s++) begin : g_slave
         cross_bar_rr_arbiter #(
            .N (N_MASTERS)
         ) u_arb (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_vec       (req_vec[s]),
            .release_grant (s_ack[s]),
            .grant_idx     (grant[s]),
            .busy          (busy[s])
         );
      end
   endgenerate

   // Forward path: s_req follows the owner's m_req so an early drop by
   // the owner is visible to the slave while the grant is still kept.
   always_comb begin
      for (int s = 0; s < N_SLAVES; s++) begin
         s_req[s]   = 1'b0;
         s_addr[s]  = '0;
         s_cmd[s]   = 1'b0;
         s_wdata[s] = '0;
         if (busy[s]) begin
            s_req[s]   = m_req[grant[s]];
            s_addr[s]  = m_addr[grant[s]];
            s_cmd[s]   = m_cmd[grant[s]];
            s_wdata[s] = m_wdata[grant[s]];
         end
      end
   end

   // Return path: one-hot by grant, OR-reduced per master. Acks from an
   // IDLE slave never reach a master.
   always_comb begin
      for (int m = 0; m < N_MASTERS; m++) begin
         m_ack[m]   = 1'b0;
         m_rdata[m] = '0;
      end
      for (int s = 0; s < N_SLAVES; s++) begin
         for (int m = 0; m < N_MASTERS; m++) begin
            if (busy[s] && s_ack[s] && (grant[s] == MIDX_W'(m))) begin
               m_ack[m]   = 1'b1;
               m_rdata[m] = m_rdata[m] | s_rdata[s];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cross_bar_nxm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cross_bar_nxm
// Description : Self-checking bench for cross_bar_nxm (3 masters, 2 slaves):
//               directed scenarios followed by randomized traffic, all
//               compared against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cross_bar_nxm;

   localparam int NM = 3;
   localparam int NS = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NM-1:0] m_req, m_cmd, m_ack;
   logic [AW-1:0] m_addr  [NM];
   logic [DW-1:0] m_wdata [NM];
   logic [DW-1:0] m_rdata [NM];
   logic [NS-1:0] s_req, s_cmd, s_ack;
   logic [AW-1:0] s_addr  [NS];
   logic [DW-1:0] s_wdata [NS];
   logic [DW-1:0] s_rdata [NS];

   cross_bar_nxm #(
      .N_MASTERS  (NM),
      .N_SLAVES   (NS),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_req   (m_req),
      .m_addr  (m_addr),
      .m_cmd   (m_cmd),
      .m_wdata (m_wdata),
      .m_ack   (m_ack),
      .m_rdata (m_rdata),
      .s_req   (s_req),
      .s_addr  (s_addr),
      .s_cmd   (s_cmd),
      .s_wdata (s_wdata),
      .s_ack   (s_ack),
      .s_rdata (s_rdata)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: per slave, whether it is owned, by whom, and which
   // master has first priority for the next arbitration.
   int            owned [NS];
   int            owner [NS];
   int            prio  [NS];
   logic [NM-1:0] exp_ack;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int target(input int m);
      return int'(m_addr[m] >> (AW - $clog2(NS)));
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         owned[s] = 0;
         owner[s] = 0;
         prio[s]  = 0;
      end
      exp_ack = '0;
   endtask

   task automatic clear_inputs();
      m_req = '0;
      m_cmd = '0;
      s_ack = '0;
      for (int m = 0; m < NM; m++) begin
         m_addr[m]  = '0;
         m_wdata[m] = '0;
      end
      for (int s = 0; s < NS; s++) s_rdata[s] = '0;
   endtask

   task automatic set_req(input int m, input logic [AW-1:0] a, input logic c, input logic [DW-1:0] d);
      m_req[m]   = 1'b1;
      m_addr[m]  = a;
      m_cmd[m]   = c;
      m_wdata[m] = d;
   endtask

   // Compare every output against the model at the falling edge.
   task automatic sample();
      logic          er, ec, ea;
      logic [AW-1:0] eaddr;
      logic [DW-1:0] ed, erd;
      @(negedge clk);
      for (int s = 0; s < NS; s++) begin
         er = 1'b0; ec = 1'b0; eaddr = '0; ed = '0;
         if (owned[s] != 0) begin
            er    = m_req[owner[s]];
            ec    = m_cmd[owner[s]];
            eaddr = m_addr[owner[s]];
            ed    = m_wdata[owner[s]];
         end
         check_val($sformatf("s_req[%0d]", s),   s_req[s],   er);
         check_val($sformatf("s_cmd[%0d]", s),   s_cmd[s],   ec);
         check_val($sformatf("s_addr[%0d]", s),  s_addr[s],  eaddr);
         check_val($sformatf("s_wdata[%0d]", s), s_wdata[s], ed);
      end
      for (int m = 0; m < NM; m++) begin
         ea = 1'b0; erd = '0;
         for (int s = 0; s < NS; s++) begin
            if (owned[s] != 0 && owner[s] == m && s_ack[s]) begin
               ea  = 1'b1;
               erd = erd | s_rdata[s];
            end
         end
         exp_ack[m] = ea;
         check_val($sformatf("m_ack[%0d]", m),   m_ack[m],   ea);
         check_val($sformatf("m_rdata[%0d]", m), m_rdata[m], erd);
      end
   endtask

   // Advance the model one clock: completions free a slave and hand
   // priority to the master after the one served; a free slave picks the
   // requester at the smallest circular distance from its priority master.
   task automatic advance();
      int best, bestd, d;
      for (int s = 0; s < NS; s++) begin
         if (owned[s] != 0) begin
            if (s_ack[s]) begin
               owned[s] = 0;
               prio[s]  = (owner[s] + 1) % NM;
            end
         end else begin
            best = -1; bestd = NM;
            for (int m = 0; m < NM; m++) begin
               if (m_req[m] && target(m) == s) begin
                  d = (m - prio[s] + NM) % NM;
                  if (d < bestd) begin
                     bestd = d;
                     best  = m;
                  end
               end
            end
            if (best >= 0) begin
               owned[s] = 1;
               owner[s] = best;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Reset entered and released one time unit after a rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      check_val("rst_s_req", s_req, 0);
      check_val("rst_m_ack", m_ack, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int cnt [2];
   int n_tx, who;

   initial begin
      rst_n = 1'b1;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Single write: M0 -> S0, slave acks in its first request cycle.
      set_req(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
      sample();
      check_val("wr_sreq_t0", s_req[0], 0);
      advance();
      s_ack[0] = 1'b1;
      sample();
      check_val("wr_sreq", s_req[0], 1);
      check_val("wr_addr", s_addr[0], 32'h0000_0010);
      check_val("wr_data", s_wdata[0], 32'hDEAD_BEEF);
      check_val("wr_cmd",  s_cmd[0], 1);
      check_val("wr_ack",  m_ack, 3'b001);
      advance();
      clear_inputs();

      // Parallel reads to both slaves.
      set_req(0, 32'h0000_0004, 1'b0, '0);
      set_req(1, 32'h8000_0004, 1'b0, '0);
      sample();
      advance();
      s_ack      = 2'b11;
      s_rdata[0] = 32'h1111_1111;
      s_rdata[1] = 32'h2222_2222;
      sample();
      check_val("par_sreq",  s_req, 2'b11);
      check_val("par_ack",   m_ack, 3'b011);
      check_val("par_rd0",   m_rdata[0], 32'h1111_1111);
      check_val("par_rd1",   m_rdata[1], 32'h2222_2222);
      check_val("par_rd2",   m_rdata[2], 0);
      advance();
      clear_inputs();

      // Contention on S1 right after reset.
      do_reset();
      set_req(0, 32'h8000_0010, 1'b0, 32'hA0A0_A0A0);
      set_req(1, 32'h8000_0020, 1'b1, 32'hB1B1_B1B1);
      sample();
      advance();
      s_ack[1] = 1'b1;
      sample();
      check_val("cont_first", s_addr[1], 32'h8000_0010);
      check_val("cont_ack0",  m_ack, 3'b001);
      advance();
      m_req[0] = 1'b0;
      s_ack    = '0;
      sample();
      check_val("cont_gap", s_req[1], 0);
      advance();
      s_ack[1] = 1'b1;
      sample();
      check_val("cont_second", s_addr[1], 32'h8000_0020);
      check_val("cont_ack1",   m_ack, 3'b010);
      advance();
      clear_inputs();
      set_req(0, 32'h8000_0030, 1'b0, '0);
      set_req(1, 32'h8000_0040, 1'b0, '0);
      sample();
      advance();
      sample();
      check_val("cont_again", s_addr[1], 32'h8000_0030);
      advance();
      clear_inputs();

      // Fairness: M0 and M1 request S0 back to back.
      do_reset();
      set_req(0, 32'h0000_0020, 1'b0, 32'h0000_0000);
      set_req(1, 32'h0000_0040, 1'b1, 32'h0000_1111);
      s_ack[0]   = 1'b1;
      s_rdata[0] = 32'h0F0F_0F0F;
      cnt[0] = 0; cnt[1] = 0; n_tx = 0;
      for (int c = 0; c < 40 && n_tx < 10; c++) begin
         sample();
         if (m_ack[0] || m_ack[1]) begin
            who = m_ack[1] ? 1 : 0;
            check_val("fair_order", who, n_tx % 2);
            cnt[who]++;
            n_tx++;
         end
         advance();
      end
      check_val("fair_cnt0", cnt[0], 5);
      check_val("fair_cnt1", cnt[1], 5);
      clear_inputs();

      // Asynchronous reset while S0 is owned by M1.
      do_reset();
      set_req(1, 32'h0000_0100, 1'b1, 32'h5555_AAAA);
      sample();
      advance();
      sample();
      check_val("mid_busy", s_req[0], 1);
      advance();
      #1;
      rst_n = 1'b0;
      #1;
      check_val("mid_sreq",  s_req, 0);
      check_val("mid_saddr", s_addr[0], 0);
      check_val("mid_sdata", s_wdata[0], 0);
      check_val("mid_scmd",  s_cmd, 0);
      check_val("mid_mack",  m_ack, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sample();
      advance();
      s_ack[0]   = 1'b1;
      s_rdata[0] = 32'h7777_0001;
      sample();
      check_val("post_rst_ack", m_ack, 3'b010);
      check_val("post_rst_rd",  m_rdata[1], 32'h7777_0001);
      advance();
      clear_inputs();

      // Spurious ack on an idle S1.
      s_ack[1]   = 1'b1;
      s_rdata[1] = 32'hBAD0_BAD0;
      sample();
      check_val("spur_ack", m_ack, 0);
      advance();
      s_ack = '0;
      set_req(0, 32'h8000_0040, 1'b0, '0);
      sample();
      check_val("spur_idle", s_req[1], 0);
      advance();
      s_ack[1]   = 1'b1;
      s_rdata[1] = 32'h0000_1234;
      sample();
      check_val("spur_next_ack", m_ack, 3'b001);
      check_val("spur_next_rd",  m_rdata[0], 32'h0000_1234);
      advance();
      clear_inputs();

      // Randomized traffic: masters follow the hold-until-ack protocol,
      // slaves ack at random (including while idle).
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         for (int m = 0; m < NM; m++) begin
            if (exp_ack[m]) begin
               m_req[m] = 1'b0;
            end else if (!m_req[m] && $urandom_range(2) == 0) begin
               set_req(m, AW'($urandom), 1'($urandom), DW'($urandom));
            end
         end
         for (int s = 0; s < NS; s++) begin
            s_ack[s]   = ($urandom_range(4) < 2);
            s_rdata[s] = DW'($urandom);
         end
         sample();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
